// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with round-robin replacement
// and an uncached single-word bypass path for MMIO.
module cache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic                    op,
    input  logic                    uncached,
    input  logic [31:0]             addr,
    input  logic [3:0]              wstrb,
    input  logic [31:0]             wdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             rdata,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [31:0]             rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [31:0]             ret_data,
    output logic                    wr_req,
    output logic [2:0]              wr_type,
    output logic [31:0]             wr_addr,
    output logic [3:0]              wr_wstrb,
    output logic [32*LINE_WORDS-1:0] wr_data,
    input  logic                    wr_rdy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int OFF_W = WRD_W + 2;
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WAY_W = $clog2(WAYS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS    = 3'd2;
    localparam logic [2:0] S_REPLACE = 3'd3;
    localparam logic [2:0] S_REFILL  = 3'd4;

    localparam logic [0:0] WB_IDLE  = 1'b0;
    localparam logic [0:0] WB_WRITE = 1'b1;

    logic [2:0] state, nxt;
    logic [0:0] wb_state;

    logic        req_op, req_unc;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx, in_idx;
    logic [WRD_W-1:0] req_word, in_word;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][LINE_WORDS][SETS];
    logic [TAG_W-1:0] tag_q    [WAYS];
    logic [31:0]      line_q   [WAYS][LINE_WORDS];
    logic [WAYS-1:0]  v_q      [SETS];
    logic [WAYS-1:0]  d_q      [SETS];
    logic [WAY_W-1:0] rr_q     [SETS];

    logic [WAY_W-1:0] wb_way;
    logic [IDX_W-1:0] wb_idx;
    logic [WRD_W-1:0] wb_word;
    logic [3:0]       wb_wstrb;
    logic [31:0]      wb_wdata;

    logic [WRD_W-1:0] cnt;
    logic [WAYS-1:0]  hit_way;
    logic [WAY_W-1:0] hit_w, victim;
    logic             lookup_hit, st_hit, hazard;
    logic             vic_dirty, ret_fin, fill_we;
    logic [31:0]      fill_word;

    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_word = req_addr[2 +: WRD_W];
    assign in_idx   = addr[OFF_W +: IDX_W];
    assign in_word  = addr[2 +: WRD_W];

    always_comb begin
        hit_way = '0;
        hit_w   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (v_q[req_idx][w] && tag_q[w] == req_tag) begin
                hit_way[w] = 1'b1;
                hit_w      = WAY_W'(w);
            end
        end
    end

    assign lookup_hit = (state == S_LOOKUP) && !req_unc && (|hit_way);
    assign st_hit     = lookup_hit && req_op;
    assign victim     = rr_q[req_idx];
    assign vic_dirty  = v_q[req_idx][victim] && d_q[req_idx][victim];
    assign ret_fin    = ret_valid && ret_last;
    assign fill_we    = (state == S_REFILL) && ret_valid && !req_unc;

    // A load must not read a word the store path has not yet written.
    assign hazard = valid && !op &&
        ((st_hit && in_idx == req_idx && in_word == req_word) ||
         (wb_state == WB_WRITE && in_word == wb_word));

    assign addr_ok = valid && !hazard &&
        ((state == S_IDLE) || lookup_hit);

    assign data_ok =
        ((state == S_LOOKUP) && (lookup_hit || req_op)) ||
        ((state == S_REFILL) && !req_op && ret_valid &&
         (req_unc ? ret_last : (cnt == req_word)));

    assign rdata = (state == S_REFILL) ? ret_data
                                       : line_q[hit_w][req_word];

    assign rd_req  = (state == S_REPLACE);
    assign rd_type = req_unc ? 3'b010 : 3'b100;
    assign rd_addr = req_unc ? req_addr
                             : {req_tag, req_idx, {OFF_W{1'b0}}};

    assign wr_req   = (state == S_MISS) && wr_rdy &&
                      (req_unc ? req_op : vic_dirty);
    assign wr_type  = req_unc ? 3'b010 : 3'b100;
    assign wr_addr  = req_unc ? req_addr
                              : {tag_q[victim], req_idx, {OFF_W{1'b0}}};
    assign wr_wstrb = req_unc ? req_wstrb : 4'hf;

    always_comb begin
        wr_data = '0;
        if (req_unc) begin
            wr_data[31:0] = req_wdata;
        end else begin
            for (int k = 0; k < LINE_WORDS; k++)
                wr_data[32*k +: 32] = line_q[victim][k];
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++)
            fill_word[8*b +: 8] =
                (req_op && cnt == req_word && req_wstrb[b]) ?
                req_wdata[8*b +: 8] : ret_data[8*b +: 8];
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (addr_ok) nxt = S_LOOKUP;
            S_LOOKUP: begin
                if (req_unc)         nxt = S_MISS;
                else if (lookup_hit) nxt = addr_ok ? S_LOOKUP : S_IDLE;
                else                 nxt = S_MISS;
            end
            S_MISS: begin
                if (req_unc && !req_op) nxt = S_REPLACE;
                else if (wr_rdy)        nxt = req_unc ? S_IDLE : S_REPLACE;
            end
            S_REPLACE: if (rd_rdy)  nxt = S_REFILL;
            S_REFILL:  if (ret_fin) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wb_state <= WB_IDLE;
            cnt      <= '0;
            for (int s = 0; s < SETS; s++) begin
                v_q[s]  <= '0;
                d_q[s]  <= '0;
                rr_q[s] <= '0;
            end
        end else begin
            state    <= nxt;
            wb_state <= st_hit ? WB_WRITE : WB_IDLE;
            if (state == S_REPLACE)
                cnt <= '0;
            else if (state == S_REFILL && ret_valid)
                cnt <= cnt + WRD_W'(1);
            if (fill_we && ret_last) begin
                v_q[req_idx][victim] <= 1'b1;
                d_q[req_idx][victim] <= req_op;
                rr_q[req_idx]        <= victim + WAY_W'(1);
            end
            if (wb_state == WB_WRITE)
                d_q[wb_idx][wb_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (addr_ok) begin
            req_op    <= op;
            req_unc   <= uncached;
            req_addr  <= addr;
            req_wstrb <= wstrb;
            req_wdata <= wdata;
        end
        if (st_hit) begin
            wb_way   <= hit_w;
            wb_idx   <= req_idx;
            wb_word  <= req_word;
            wb_wstrb <= req_wstrb;
            wb_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_state == WB_WRITE) begin
            for (int b = 0; b < 4; b++)
                if (wb_wstrb[b])
                    data_mem[wb_way][wb_word][wb_idx][8*b +: 8] <=
                        wb_wdata[8*b +: 8];
        end
        if (fill_we)
            data_mem[victim][cnt][req_idx] <= fill_word;
        if (fill_we && ret_last)
            tag_mem[victim][req_idx] <= req_tag;
    end

    // Registered read; the pending buffer write is forwarded so a
    // victim line captured alongside it is never stale.
    always_ff @(posedge clk) begin
        if (addr_ok) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w] <= tag_mem[w][in_idx];
                for (int k = 0; k < LINE_WORDS; k++)
                    line_q[w][k] <= data_mem[w][k][in_idx];
            end
        end
        if (wb_state == WB_WRITE &&
            wb_idx == (addr_ok ? in_idx : req_idx)) begin
            for (int b = 0; b < 4; b++)
                if (wb_wstrb[b])
                    line_q[wb_way][wb_word][8*b +: 8] <=
                        wb_wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway with an inline bridge model.
// Bridge returns beat k of a read at address a as (a+4k)^5A5A0000.
module tb_cache_nway;
    logic         clk = 1'b0;
    logic         rst, valid, op, uncached;
    logic [31:0]  addr, wdata, rdata, rd_addr, wr_addr, ret_data;
    logic [3:0]   wstrb, wr_wstrb;
    logic         addr_ok, data_ok, rd_req, rd_rdy;
    logic         ret_valid, ret_last, wr_req, wr_rdy;
    logic [2:0]   rd_type, wr_type;
    logic [127:0] wr_data;

    int passed = 0;
    int total  = 0;

    logic         got;
    logic [31:0]  rdat, rd_a, wr_a;
    logic [2:0]   rd_t, wr_t;
    logic [3:0]   wr_s;
    logic [127:0] wr_d;
    int           dbeat, rd_seen, wr_seen, left, bidx, wcnt;
    logic         ok;

    cache_nway #(.WAYS(4), .SETS(256), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .op(op),
        .uncached(uncached), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type),
        .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last),
        .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type),
        .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] beat(input logic [31:0] a,
                                         input int k);
        return (a + 32'(4 * k)) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clr();
        got = 0; rdat = '0; dbeat = -1;
        rd_seen = 0; rd_t = '0; rd_a = '0;
        wr_seen = 0; wr_t = '0; wr_a = '0; wr_s = '0; wr_d = '0;
    endtask

    task automatic step();
        @(negedge clk);
        if (data_ok) begin
            got = 1; rdat = rdata;
            dbeat = ret_valid ? bidx : -1;
        end
        if (wr_req) begin
            wr_seen++; wr_t = wr_type; wr_a = wr_addr;
            wr_s = wr_wstrb; wr_d = wr_data;
        end
        if (rd_req && !rd_rdy) begin
            rd_seen++; rd_t = rd_type; rd_a = rd_addr;
            rd_rdy = 1'b1;
        end
        @(posedge clk); #1;
        if (ret_valid) begin bidx++; left--; end
        if (rd_rdy) begin
            rd_rdy = 1'b0;
            left = (rd_t == 3'b100) ? 4 : 1;
            bidx = 0;
        end
        ret_valid = (left > 0);
        ret_last  = (left == 1);
        ret_data  = (left > 0) ? beat(rd_a, bidx) : '0;
    endtask

    task automatic issue(input logic o, input logic u,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int wn);
        logic acc;
        valid = 1'b1; op = o; uncached = u;
        addr = a; wstrb = s; wdata = d;
        wn = 0; acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            if (addr_ok) acc = 1'b1;
            else begin wn++; @(posedge clk); #1; end
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic run(input logic o, input logic u,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
        int wn;
        clr();
        issue(o, u, a, s, d, wn);
        repeat (12) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = 1'b0; op = 1'b0; uncached = 1'b0;
        addr = '0; wstrb = '0; wdata = '0; rd_rdy = 1'b0;
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        wr_rdy = 1'b1; left = 0; bidx = 0;
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_addr_ok_idle", addr_ok, 0);
        @(posedge clk); #1;

        // T1 cold load then reload
        clr();
        issue(0, 0, 32'h1C00_0014, 4'h0, 0, wcnt);
        chk("t1_addr_ok_first", wcnt, 0);
        repeat (12) step();
        chk("t1_rd_seen", rd_seen, 1);
        chk("t1_rd_type", rd_t, 3'b100);
        chk("t1_rd_addr", rd_a, 32'h1C00_0010);
        chk("t1_data_ok", got, 1);
        chk("t1_ok_beat", dbeat, 1);
        chk("t1_rdata", rdat, beat(32'h1C00_0010, 1));
        chk("t1_no_wr", wr_seen, 0);
        run(0, 0, 32'h1C00_0014, 4'h0, 0);
        chk("t1_hit_no_rd", rd_seen, 0);
        chk("t1_hit_ok", got, 1);
        chk("t1_hit_rdata", rdat, beat(32'h1C00_0010, 1));

        // T2 store hit with a load right behind it
        valid = 1'b1; op = 1'b1; uncached = 1'b0;
        addr = 32'h1C00_0014; wstrb = 4'hf; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_store_acc", addr_ok, 1);
        @(posedge clk); #1;
        op = 1'b0;
        @(negedge clk);
        chk("t2_hazard", addr_ok, 0);
        chk("t2_store_ok", data_ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (addr_ok) ok = 1'b1;
        end
        chk("t2_load_acc", ok, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        chk("t2_load_ok", data_ok, 1);
        chk("t2_rdata", rdata, 32'hDEAD_BEEF);
        chk("t2_no_rd", rd_req, 0);
        @(posedge clk); #1;
        clr();
        repeat (3) step();

        // T3 five store misses in set 1
        for (int t = 0; t < 5; t++) begin
            run(1, 0, (32'(t) << 12) | 32'h10, 4'hf, 32'hA0 + 32'(t));
            chk("t3_posted_ok", got, 1);
            chk("t3_refill", rd_seen, 1);
            if (t < 3) chk("t3_no_wb", wr_seen, 0);
            if (t == 3) begin
                chk("t3_wb3", wr_seen, 1);
                chk("t3_wb3_type", wr_t, 3'b100);
                chk("t3_wb3_strb", wr_s, 4'hf);
                chk("t3_wb3_addr", wr_a, 32'h1C00_0010);
                chk("t3_wb3_data", wr_d,
                    {beat(32'h1C00_0010, 3), beat(32'h1C00_0010, 2),
                     32'hDEAD_BEEF, beat(32'h1C00_0010, 0)});
                chk("t3_rr_wrap", 128'(dut.rr_q[1]), 1);
            end
            if (t == 4) begin
                chk("t3_wb4", wr_seen, 1);
                chk("t3_wb4_addr", wr_a, 32'h0000_0010);
                chk("t3_wb4_data", wr_d,
                    {beat(32'h10, 3), beat(32'h10, 2),
                     beat(32'h10, 1), 32'h0000_00A0});
            end
        end

        // T4 uncached load, then cached load of same address
        run(0, 1, 32'hBFAF_8004, 4'h0, 0);
        chk("t4_rd_type", rd_t, 3'b010);
        chk("t4_rd_addr", rd_a, 32'hBFAF_8004);
        chk("t4_ok", got, 1);
        chk("t4_rdata", rdat, beat(32'hBFAF_8004, 0));
        run(0, 0, 32'hBFAF_8004, 4'h0, 0);
        chk("t4_cached_miss", rd_seen, 1);
        chk("t4_cached_type", rd_t, 3'b100);
        chk("t4_cached_addr", rd_a, 32'hBFAF_8000);
        chk("t4_cached_rdata", rdat, beat(32'hBFAF_8000, 1));
        chk("t4_invalid_no_wb", wr_seen, 0);

        // T5 uncached store leaves the arrays alone
        run(1, 1, 32'hBFAF_8000, 4'b0011, 32'h0000_1234);
        chk("t5_wr", wr_seen, 1);
        chk("t5_wr_type", wr_t, 3'b010);
        chk("t5_wr_addr", wr_a, 32'hBFAF_8000);
        chk("t5_wr_strb", wr_s, 4'b0011);
        chk("t5_wr_data", wr_d[31:0], 32'h0000_1234);
        chk("t5_no_rd", rd_seen, 0);
        chk("t5_ok", got, 1);
        run(0, 0, 32'hBFAF_8000, 4'h0, 0);
        chk("t5_hit_no_rd", rd_seen, 0);
        chk("t5_hit_rdata", rdat, beat(32'hBFAF_8000, 0));

        // T6 reset in the middle of a refill
        clr();
        issue(0, 0, 32'h0000_2020, 4'h0, 0, wcnt);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (ret_valid && bidx == 1) ok = 1'b1;
        end
        chk("t6_in_refill", ok, 1);
        rst = 1'b1; ret_valid = 1'b0; ret_last = 1'b0; left = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rd_req", rd_req, 0);
        chk("t6_data_ok", data_ok, 0);
        chk("t6_addr_ok", addr_ok, 0);
        @(posedge clk); #1;
        run(0, 0, 32'h0000_2020, 4'h0, 0);
        chk("t6_miss", rd_seen, 1);
        chk("t6_rd_addr", rd_a, 32'h0000_2020);
        chk("t6_rdata", rdat, beat(32'h0000_2020, 0));
        run(0, 0, 32'h1C00_0014, 4'h0, 0);
        chk("t6_old_line_gone", rd_seen, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
